// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use stall and
// redirect flush, driven from a private shadow copy of EX/MEM/WB destination state.
module hazard_fwd_ctrl #(
    parameter int unsigned CNT_W     = 32,
    parameter logic [1:0]  WSEL_LOAD = 2'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rR1,
    input  logic [4:0]       id_rR2,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic [4:0]       id_wR,
    input  logic             id_rf_we,
    input  logic [1:0]       id_rf_wsel,
    input  logic             ex_redirect,
    output logic [2:0]       rR1_forward,
    output logic [2:0]       rR2_forward,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             pipeline_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       ex_we_r,  mem_we_r,  wb_we_r;
    logic [4:0] ex_wr_r,  mem_wr_r,  wb_wr_r;
    logic       ex_ld_r,  mem_ld_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic       load_use_s;
    logic       ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s, wb_hit1_s, wb_hit2_s;

    // x0 is hard-wired zero, so it can never be a forwarding or stall source
    function automatic logic stage_hit(input logic we, input logic [4:0] wr,
                                       input logic [4:0] r, input logic re);
        return we & re & (wr == r) & (r != 5'd0);
    endfunction

    function automatic logic [2:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                           input logic mem_hit, input logic mem_ld,
                                           input logic wb_hit);
        logic [2:0] sel;
        if (ex_hit && !ex_ld)       sel = 3'd1;
        else if (mem_hit && mem_ld) sel = 3'd4;
        else if (mem_hit)           sel = 3'd2;
        else if (wb_hit)            sel = 3'd3;
        else                        sel = 3'd0;
        return sel;
    endfunction

    // Hazard detection, forward selection and pipeline control
    always_comb begin
        ex_hit1_s   = stage_hit(ex_we_r,  ex_wr_r,  id_rR1, id_re1);
        ex_hit2_s   = stage_hit(ex_we_r,  ex_wr_r,  id_rR2, id_re2);
        mem_hit1_s  = stage_hit(mem_we_r, mem_wr_r, id_rR1, id_re1);
        mem_hit2_s  = stage_hit(mem_we_r, mem_wr_r, id_rR2, id_re2);
        wb_hit1_s   = stage_hit(wb_we_r,  wb_wr_r,  id_rR1, id_re1);
        wb_hit2_s   = stage_hit(wb_we_r,  wb_wr_r,  id_rR2, id_re2);
        load_use_s  = id_valid & ex_ld_r & (ex_hit1_s | ex_hit2_s);

        rR1_forward    = 3'd0;
        rR2_forward    = 3'd0;
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        flush_if_id    = 1'b0;
        pipeline_flush = 1'b0;

        if (id_valid && !load_use_s) begin
            rR1_forward = fwd_sel(ex_hit1_s, ex_ld_r, mem_hit1_s, mem_ld_r, wb_hit1_s);
            rR2_forward = fwd_sel(ex_hit2_s, ex_ld_r, mem_hit2_s, mem_ld_r, wb_hit2_s);
        end else begin
            rR1_forward = 3'd0;
            rR2_forward = 3'd0;
        end

        if (ex_redirect) begin
            flush_if_id    = 1'b1;
            pipeline_flush = 1'b1;
        end else if (load_use_s) begin
            stall_pc       = 1'b1;
            stall_if_id    = 1'b1;
            pipeline_flush = 1'b1;
        end else begin
            pipeline_flush = 1'b0;
        end
    end

    // Shadow EX/MEM/WB destination state; downstream stages never stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_we_r  <= 1'b0;  ex_wr_r  <= 5'd0;  ex_ld_r  <= 1'b0;
            mem_we_r <= 1'b0;  mem_wr_r <= 5'd0;  mem_ld_r <= 1'b0;
            wb_we_r  <= 1'b0;  wb_wr_r  <= 5'd0;
        end else begin
            wb_we_r  <= mem_we_r;  wb_wr_r  <= mem_wr_r;
            mem_we_r <= ex_we_r;   mem_wr_r <= ex_wr_r;   mem_ld_r <= ex_ld_r;
            if (pipeline_flush) begin
                ex_we_r <= 1'b0;
                ex_wr_r <= 5'd0;
                ex_ld_r <= 1'b0;
            end else begin
                ex_we_r <= id_rf_we & id_valid;
                ex_wr_r <= id_wR;
                ex_ld_r <= (id_rf_wsel == WSEL_LOAD);
            end
        end
    end

    // Performance event counters; a redirect masks a concurrent load-use stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (load_use_s && !ex_redirect) stall_cnt_r <= stall_cnt_r + CNT_ONE;
            if (ex_redirect)                flush_cnt_r <= flush_cnt_r + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: an instruction-history model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_re1, id_re2, id_rf_we, ex_redirect;
    logic [4:0]  id_rR1, id_rR2, id_wR;
    logic [1:0]  id_rf_wsel;
    logic [2:0]  rR1_forward, rR2_forward;
    logic        stall_pc, stall_if_id, flush_if_id, pipeline_flush;
    logic [31:0] stall_cnt, flush_cnt;

    int tests  = 0;
    int errors = 0;

    hazard_fwd_ctrl #(.CNT_W(32), .WSEL_LOAD(2'd2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .id_re1(id_re1), .id_re2(id_re2), .id_wR(id_wR), .id_rf_we(id_rf_we),
        .id_rf_wsel(id_rf_wsel), .ex_redirect(ex_redirect),
        .rR1_forward(rR1_forward), .rR2_forward(rR2_forward),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .pipeline_flush(pipeline_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of instructions that entered EX, youngest first (index = age)
    typedef struct {
        logic       writes;
        logic [4:0] dest;
        logic       is_load;
    } instr_t;

    instr_t      hist[$];
    logic [31:0] m_stall, m_flush;

    function automatic bit reads_from(instr_t w, logic [4:0] r, logic re);
        return re && w.writes && w.dest == r && r != 5'd0;
    endfunction

    function automatic logic [2:0] model_code(logic [4:0] r, logic re, bit lu);
        if (!id_valid || lu) return 3'd0;
        for (int age = 0; age < hist.size(); age++) begin
            if (reads_from(hist[age], r, re)) begin
                if (age == 0) return 3'd1;
                if (age == 1) return hist[age].is_load ? 3'd4 : 3'd2;
                return 3'd3;
            end
        end
        return 3'd0;
    endfunction

    // Per-cycle comparison against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        if (rst) begin
            hist.delete();
            m_stall = 32'd0;
            m_flush = 32'd0;
            chk("rst_codes", {26'd0, rR1_forward, rR2_forward}, 32'd0);
            chk("rst_ctrl", {28'd0, stall_pc, stall_if_id, flush_if_id, pipeline_flush}, 32'd0);
            chk("rst_cnts", stall_cnt | flush_cnt, 32'd0);
        end else begin
            bit lu;
            bit bubble;
            instr_t nx;
            lu = 1'b0;
            if (id_valid && hist.size() > 0 && hist[0].is_load)
                lu = reads_from(hist[0], id_rR1, id_re1) || reads_from(hist[0], id_rR2, id_re2);
            bubble = ex_redirect || lu;
            chk("m_fwd1", {29'd0, rR1_forward}, {29'd0, model_code(id_rR1, id_re1, lu)});
            chk("m_fwd2", {29'd0, rR2_forward}, {29'd0, model_code(id_rR2, id_re2, lu)});
            chk("m_stall_pc", {31'd0, stall_pc}, {31'd0, lu && !ex_redirect});
            chk("m_stall_if_id", {31'd0, stall_if_id}, {31'd0, lu && !ex_redirect});
            chk("m_flush_if_id", {31'd0, flush_if_id}, {31'd0, ex_redirect});
            chk("m_pipe_flush", {31'd0, pipeline_flush}, {31'd0, bubble});
            chk("m_stall_cnt", stall_cnt, m_stall);
            chk("m_flush_cnt", flush_cnt, m_flush);
            if (bubble) nx = '{writes: 1'b0, dest: 5'd0, is_load: 1'b0};
            else        nx = '{writes: id_valid && id_rf_we, dest: id_wR, is_load: id_rf_wsel == 2'd2};
            hist.push_front(nx);
            if (hist.size() > 3) void'(hist.pop_back());
            if (ex_redirect) m_flush = m_flush + 32'd1;
            else if (lu)     m_stall = m_stall + 32'd1;
        end
    end

    // Present one instruction to ID just after a rising edge; returns once outputs settle
    task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic e1, input logic e2, input logic [4:0] wr,
                         input logic we, input logic [1:0] ws, input logic rd);
        @(posedge clk);
        #1;
        id_valid = v; id_rR1 = r1; id_rR2 = r2; id_re1 = e1; id_re2 = e2;
        id_wR = wr; id_rf_we = we; id_rf_wsel = ws; ex_redirect = rd;
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rR1 = 5'd0; id_rR2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
        id_wR = 5'd0; id_rf_we = 1'b0; id_rf_wsel = 2'd0; ex_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU result forwarded from EX, then MEM, then WB, then regfile
        issue(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
        chk("ex_fwd", {29'd0, rR1_forward}, 32'd1);
        chk("ex_fwd_nostall", {31'd0, stall_pc}, 32'd0);
        issue(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
        chk("mem_fwd", {29'd0, rR2_forward}, 32'd2);
        issue(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
        chk("wb_fwd", {29'd0, rR1_forward}, 32'd3);
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
        chk("rf_nofwd", {26'd0, rR1_forward, rR2_forward}, 32'd0);

        // Load-use: one stall cycle, then load data from MEM on both sources
        issue(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'd2, 1'b0);
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
        chk("lu_ctrl", {28'd0, stall_pc, stall_if_id, flush_if_id, pipeline_flush}, 32'b1101);
        chk("lu_codes", {26'd0, rR1_forward, rR2_forward}, 32'd0);
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 2'd0, 1'b0);
        chk("lu_after_codes", {26'd0, rR1_forward, rR2_forward}, {26'd0, 3'd4, 3'd4});
        chk("lu_after_stall", {31'd0, stall_pc}, 32'd0);
        chk("lu_stall_cnt", stall_cnt, 32'd1);

        // Load to x0 never stalls
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 2'd0, 1'b0);
        chk("x0_ctrl", {28'd0, stall_pc, stall_if_id, flush_if_id, pipeline_flush}, 32'd0);
        chk("x0_codes", {26'd0, rR1_forward, rR2_forward}, 32'd0);
        nop();
        chk("x0_stall_cnt", stall_cnt, 32'd1);

        // Redirect beats load-use; the flushed slot carries no destination
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
        issue(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 2'd0, 1'b1);
        chk("rd_ctrl", {28'd0, stall_pc, stall_if_id, flush_if_id, pipeline_flush}, 32'b0011);
        issue(1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
        chk("rd_bubble_codes", {26'd0, rR1_forward, rR2_forward}, {26'd0, 3'd0, 3'd4});
        chk("rd_flush_cnt", flush_cnt, 32'd1);
        chk("rd_stall_cnt", stall_cnt, 32'd1);

        // Youngest writer wins; disabled read port never forwards
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd5, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 2'd0, 1'b0);
        chk("young_codes", {26'd0, rR1_forward, rR2_forward}, {26'd0, 3'd1, 3'd0});

        // Invalid ID slot: its write enable is ignored, and it never stalls
        issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 2'd2, 1'b0);
        issue(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 2'd2, 1'b0);
        chk("inv_codes", {29'd0, rR1_forward}, 32'd0);
        issue(1'b0, 5'd12, 5'd12, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("inv_nostall", {28'd0, stall_pc, stall_if_id, flush_if_id, pipeline_flush}, 32'd0);

        // Asynchronous reset with writers in flight
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 2'd0, 1'b0);
        issue(1'b1, 5'd10, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("pre_rst_codes", {26'd0, rR1_forward, rR2_forward}, {26'd0, 3'd1, 3'd2});
        rst = 1'b1;
        #1;
        chk("rst_now_codes", {26'd0, rR1_forward, rR2_forward}, 32'd0);
        chk("rst_now_cnts", stall_cnt | flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("post_rst_codes", {26'd0, rR1_forward, rR2_forward}, 32'd0);
        chk("post_rst_stall", stall_cnt, 32'd0);
        chk("post_rst_flush", flush_cnt, 32'd0);
        nop();
        nop();
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
